mem_arbiter: RTL and testbench

//  Single-port memory arbiter directly downstream of icache and dcache. It consumes

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2,
        RETRY = 2'd3
    } arb_state_t;

    // Width of the per-transaction error counter; it saturates rather than wraps.
    localparam int RETRY_CNT_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache. One transaction in flight;
// data side wins contests unless it won the previous one, so fetch cannot starve.
// RAM-side outputs come only from registers latched at grant time.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ERR_RETRY_MAX = 3
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       iREN,
    input  word_t      iaddr,
    output logic       iwait,
    output word_t      iload,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       dwait,
    output word_t      dload,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  logic [1:0] ramstate,
    output logic       memerr
);

    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(ERR_RETRY_MAX);

    arb_state_t             state;
    arb_state_t             next_state;
    ramstate_t              ram_st;
    logic                   serve_d;     // 1 = current transaction belongs to dcache
    logic                   last_d;      // 1 = dcache got the most recent ack
    logic                   lat_wen;     // latched operation of the current transaction
    logic                   next_wen;
    logic                   next_serv;
    logic                   d_req;
    logic                   grant_d;
    logic                   owner_req;   // granted requester still asserting its enable
    logic [RETRY_CNT_W-1:0] retry_cnt;
    logic [RETRY_CNT_W-1:0] retry_inc;

    assign ram_st    = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign grant_d   = d_req && (!iREN || !last_d);
    assign owner_req = serve_d ? d_req : iREN;
    assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
    assign next_serv = (next_state == DSERV) || (next_state == ISERV);

    // Read data is a straight pass-through; only meaningful while the matching wait is low.
    assign iload = ramload;
    assign dload = ramload;

    // Next-state decision, acknowledge strobes and the operation the next cycle will drive.
    always_comb begin
        next_state = state;
        next_wen   = lat_wen;
        iwait      = 1'b1;
        dwait      = 1'b1;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = DSERV;
                    next_wen   = dWEN;
                end else if (iREN) begin
                    next_state = ISERV;
                    next_wen   = 1'b0;
                end
            end
            DSERV, ISERV: begin
                if (!owner_req) begin
                    next_state = IDLE;
                end else if (ram_st == ACCESS) begin
                    next_state = IDLE;
                    if (state == DSERV) dwait = 1'b0;
                    else                iwait = 1'b0;
                end else if (ram_st == ERROR) begin
                    next_state = RETRY;
                end
            end
            RETRY: begin
                if (!owner_req) next_state = IDLE;
                else            next_state = serve_d ? DSERV : ISERV;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, grant latches, retry counter, sticky error flag and registered RAM enables.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            serve_d   <= 1'b0;
            last_d    <= 1'b0;
            lat_wen   <= 1'b0;
            retry_cnt <= '0;
            memerr    <= 1'b0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
        end else begin
            state  <= next_state;
            ramREN <= next_serv && !next_wen;
            ramWEN <= next_serv && next_wen;
            unique case (state)
                IDLE: begin
                    retry_cnt <= '0;
                    if (next_state == DSERV) begin
                        serve_d  <= 1'b1;
                        lat_wen  <= dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                    end else if (next_state == ISERV) begin
                        serve_d  <= 1'b0;
                        lat_wen  <= 1'b0;
                        ramaddr  <= iaddr;
                        ramstore <= '0;
                    end
                end
                DSERV, ISERV: begin
                    if (owner_req && ram_st == ACCESS) begin
                        last_d    <= (state == DSERV);
                        retry_cnt <= '0;
                    end else if (next_state == RETRY) begin
                        retry_cnt <= retry_inc;
                        if (retry_inc > RETRY_LIMIT) memerr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized cache/RAM traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAXR = 3;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t rstate;
    logic      iwait, dwait, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    mem_arbiter #(.ERR_RETRY_MAX(MAXR)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(rstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Model: owner 0 = nobody, 1 = icache, 2 = dcache. A "pause" is the one-cycle
    // back-off after an error during which the RAM sees no enable.
    int    m_own;
    bit    m_pause, m_err, m_lastd, m_wr, m_iack, m_dack;
    int    m_cnt;
    word_t m_addr, m_store;

    task automatic model_reset();
        m_own = 0; m_pause = 0; m_err = 0; m_lastd = 0; m_wr = 0;
        m_cnt = 0; m_addr = '0; m_store = '0; m_iack = 0; m_dack = 0;
    endtask

    // Compare one cycle's outputs before the edge, then advance the model through it.
    task automatic cycle();
        bit serving, still, ack, dreq;
        @(negedge CLK);
        dreq    = dREN || dWEN;
        serving = (m_own != 0) && !m_pause;
        still   = (m_own == 1) ? iREN : (m_own == 2) ? dreq : 1'b0;
        ack     = serving && still && (rstate == ACCESS);
        m_iack  = ack && (m_own == 1);
        m_dack  = ack && (m_own == 2);
        check("ramREN",   32'(ramREN),   32'(serving && !m_wr));
        check("ramWEN",   32'(ramWEN),   32'(serving && m_wr));
        check("ramaddr",  ramaddr,       m_addr);
        check("ramstore", ramstore,      m_store);
        check("iwait",    32'(iwait),    32'(!m_iack));
        check("dwait",    32'(dwait),    32'(!m_dack));
        check("memerr",   32'(memerr),   32'(m_err));
        if (m_iack) check("iload", iload, ramload);
        if (m_dack) check("dload", dload, ramload);
        if (m_own == 0) begin
            if (dreq && (!iREN || !m_lastd)) begin
                m_own = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN;
            end else if (iREN) begin
                m_own = 1; m_addr = iaddr; m_store = '0; m_wr = 0;
            end
            m_cnt = 0;
        end else if (!still) begin
            m_own = 0; m_pause = 0;
        end else if (m_pause) begin
            m_pause = 0;
        end else if (ack) begin
            m_lastd = (m_own == 2); m_own = 0; m_cnt = 0;
        end else if (rstate == ERROR) begin
            m_pause = 1;
            m_cnt++;
            if (m_cnt > MAXR) m_err = 1;
        end
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse issued mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        nRST = 1'b0;
        #2;
        check("rst_ramREN",   32'(ramREN),   32'd0);
        check("rst_ramWEN",   32'(ramWEN),   32'd0);
        check("rst_ramaddr",  ramaddr,       32'd0);
        check("rst_ramstore", ramstore,      32'd0);
        check("rst_iwait",    32'(iwait),    32'd1);
        check("rst_dwait",    32'(dwait),    32'd1);
        check("rst_memerr",   32'(memerr),   32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
    endtask

    initial begin
        nRST = 1'b1;
        idle_inputs();
        iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h1234_5678; rstate = FREE;
        model_reset();
        #1;
        do_reset();

        // 1: single fetch, two BUSY cycles then ACCESS
        iREN = 1; iaddr = 32'h40; rstate = BUSY;
        cycle();
        cycle();
        check("t1_ramaddr", ramaddr, 32'h40);
        cycle();
        rstate = ACCESS; ramload = 32'hCAFE_0001;
        cycle();
        iREN = 0; rstate = FREE;
        cycle();

        // 2: simultaneous write and fetch, both held: D first, then alternation
        iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        rstate = ACCESS;
        cycle();
        check("t2_ramstore", ramstore, 32'hDEAD_BEEF);
        check("t2_ramWEN",   32'(ramWEN), 32'd1);
        for (int k = 0; k < 8; k++) begin
            ramload = $urandom;
            cycle();
        end
        idle_inputs(); rstate = FREE;
        cycle();

        // 3: read and write both high -> write only
        dREN = 1; dWEN = 1; daddr = 32'h88; dstore = 32'h0BAD_F00D; rstate = BUSY;
        cycle();
        check("t3_ramREN", 32'(ramREN), 32'd0);
        cycle();
        rstate = ACCESS;
        cycle();
        idle_inputs(); rstate = FREE;
        cycle();

        // 4: four ERRORs then ACCESS; memerr on the fourth and sticky afterwards
        do_reset();
        iREN = 1; iaddr = 32'h200; rstate = FREE;
        cycle();
        for (int k = 0; k < 4; k++) begin
            rstate = ERROR; cycle();
            rstate = FREE;  cycle();
        end
        rstate = ACCESS; ramload = 32'h5555_AAAA;
        cycle();
        iREN = 0; rstate = FREE;
        cycle();
        check("t4_memerr_sticky", 32'(memerr), 32'd1);

        // 5: fetch aborted while BUSY; pending read granted next
        iREN = 1; iaddr = 32'h300; rstate = BUSY;
        cycle();
        dREN = 1; daddr = 32'h400;
        cycle();
        iREN = 0;
        cycle();
        cycle();
        check("t5_ramaddr", ramaddr, 32'h400);
        rstate = ACCESS;
        cycle();
        idle_inputs(); rstate = FREE;
        cycle();

        // 6: reset in the middle of a data transaction, then D wins the next contest
        dREN = 1; daddr = 32'h500; rstate = BUSY;
        cycle();
        cycle();
        do_reset();
        iREN = 1; iaddr = 32'h600;
        cycle();
        check("t6_grant_d", ramaddr, 32'h500);
        rstate = ACCESS;
        cycle();
        dREN = 0;
        cycle();
        cycle();
        idle_inputs(); rstate = FREE;
        cycle();

        // Randomized traffic with aborts, address wiggle during service and RAM errors
        for (int n = 0; n < 3000; n++) begin
            if (iREN) begin
                if (m_iack) begin
                    if ($urandom % 2 == 0) iaddr = $urandom;
                    else iREN = 0;
                end else if ($urandom % 40 == 0) iREN = 0;
                else if ($urandom % 30 == 0) iaddr = $urandom;
            end else if ($urandom % 3 == 0) begin
                iREN = 1; iaddr = $urandom;
            end
            if (dREN || dWEN) begin
                if (m_dack) begin
                    dREN = 0; dWEN = 0;
                end else if ($urandom % 40 == 0) begin
                    dREN = 0; dWEN = 0;
                end else if ($urandom % 30 == 0) begin
                    daddr = $urandom; dstore = $urandom;
                end
            end else if ($urandom % 3 == 0) begin
                case ($urandom % 3)
                    0:       begin dREN = 1; dWEN = 0; end
                    1:       begin dREN = 0; dWEN = 1; end
                    default: begin dREN = 1; dWEN = 1; end
                endcase
                daddr = $urandom; dstore = $urandom;
            end
            case ($urandom % 8)
                0, 1:    rstate = BUSY;
                2:       rstate = FREE;
                3:       rstate = ERROR;
                default: rstate = ACCESS;
            endcase
            ramload = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
